candy_inst_enc: RTL and testbench

- Instruction encoder/loader: the inverse of the Candy CPU instruction decoder.
- Accepts decoded fields (type, op, rs1, rs2, rd, imm) over a valid/ready handshake and packs them into 24-bit Candy instruction words.
- Writes the packed words sequentially into instruction memory through a write port.
- Used by the boot/test loader to fill program memory before the core is released.

---
 rtl/candy_inst_enc.sv | 153 +++++++++++++++
 tb/tb_candy_inst_enc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/candy_inst_enc.sv
// candy_inst_enc: packs decoded Candy instruction fields into 24-bit
// instruction words. The words are written one after another into
// instruction memory, starting at BASE. The boot/test loader uses this
// block to fill program memory before the core is released.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      open a load session (IDLE/DONE only)
//   in_valid / in_ready        field bundle handshake
//   in_type, in_op, in_rs1,
//   in_rs2, in_rd, in_imm      decoded fields of one instruction
//   in_last                    final bundle of the session
//   mem_we/mem_addr/mem_wdata  instruction memory write port (1-cycle latency)
//   busy, done, full, err      session status
//   word_cnt                   words written this session
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | accepting bundles, one word per cycle
// DONE  | session closed by in_last or by reaching DEPTH
module candy_inst_enc #(
  parameter int                ADDR_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [5:0]        in_op,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [3:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic                err_q;
  logic                full_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [23:0]         mem_wdata_q;

  logic [23:0]         wdata_d;
  logic                bad_d;
  logic [ADDR_W:0]     word_cnt_d;

  // Encoding and range check of the presented bundle. Only the fields a
  // type actually uses are checked; the others are don't-care.
  always_comb begin
    wdata_d = '0;
    bad_d   = 1'b0;
    unique case (in_type)
      2'b00: begin
        wdata_d = {2'b00, in_op, in_rs1, in_rs2, in_rd, 4'b0000};
      end
      2'b01: begin
        wdata_d = {2'b01, in_op[3:0], in_rs1, in_rd, in_imm[9:0]};
        bad_d   = (|in_op[5:4]) || (|in_imm[15:10]);
      end
      2'b10: begin
        wdata_d = {2'b10, in_op[3:0], in_rs1, in_rs2, in_imm[9:0]};
        bad_d   = (|in_op[5:4]) || (|in_imm[15:10]);
      end
      default: begin
        wdata_d = {2'b11, in_op[1:0], in_rd, in_imm};
        bad_d   = |in_op[5:2];
      end
    endcase
  end

  assign word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE;
      word_cnt_q  <= '0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_q      <= 1'b0;
            full_q     <= 1'b0;
            word_cnt_q <= '0;
            addr_q     <= BASE;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            if (bad_d) begin
              // Rejected bundle still closes the session if it is the last one.
              err_q <= 1'b1;
              if (in_last) state_q <= S_DONE;
            end else begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= wdata_d;
              addr_q      <= addr_q + ADDR_W'(1);
              word_cnt_q  <= word_cnt_d;
              if (word_cnt_d == DEPTH_C) begin
                full_q  <= 1'b1;
                state_q <= S_DONE;
              end else if (in_last) begin
                state_q <= S_DONE;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign full      = full_q;
  assign err       = err_q;
  assign word_cnt  = word_cnt_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_candy_inst_enc.sv
// Directed bench for candy_inst_enc. Three instances share one stimulus:
// default parameters, DEPTH=4, and BASE=8'hFE/DEPTH=4 for address wrap.
module tb_candy_inst_enc;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic [1:0]  in_type;
  logic [5:0]  in_op;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic [15:0] in_imm;

  logic       m_ready, m_we, m_busy, m_done, m_full, m_err;
  logic [7:0] m_addr;
  logic [23:0] m_wdata;
  logic [8:0] m_cnt;

  logic       d_ready, d_we, d_busy, d_done, d_full, d_err;
  logic [7:0] d_addr;
  logic [23:0] d_wdata;
  logic [8:0] d_cnt;

  logic       w_ready, w_we, w_busy, w_done, w_full, w_err;
  logic [7:0] w_addr;
  logic [23:0] w_wdata;
  logic [8:0] w_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  candy_inst_enc u_main (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(m_ready),
    .in_type(in_type), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_last(in_last), .mem_we(m_we), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .busy(m_busy), .done(m_done), .full(m_full), .err(m_err),
    .word_cnt(m_cnt)
  );

  candy_inst_enc #(.ADDR_W(8), .DEPTH(4), .BASE(8'h00)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(d_ready),
    .in_type(in_type), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_last(in_last), .mem_we(d_we), .mem_addr(d_addr),
    .mem_wdata(d_wdata), .busy(d_busy), .done(d_done), .full(d_full), .err(d_err),
    .word_cnt(d_cnt)
  );

  candy_inst_enc #(.ADDR_W(8), .DEPTH(4), .BASE(8'hFE)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(w_ready),
    .in_type(in_type), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_last(in_last), .mem_we(w_we), .mem_addr(w_addr),
    .mem_wdata(w_wdata), .busy(w_busy), .done(w_done), .full(w_full), .err(w_err),
    .word_cnt(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic [1:0] t, input logic [5:0] op, input logic [3:0] r1,
                        input logic [3:0] r2, input logic [3:0] rd, input logic [15:0] imm,
                        input logic last);
    in_valid = 1'b1;
    in_type  = t;
    in_op    = op;
    in_rs1   = r1;
    in_rs2   = r2;
    in_rd    = rd;
    in_imm   = imm;
    in_last  = last;
  endtask

  task automatic no_bundle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_type = 2'b00; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;

    // reset state
    tick(); tick();
    chk("rst_we",    {31'd0, m_we},    32'd0);
    chk("rst_ready", {31'd0, m_ready}, 32'd0);
    chk("rst_busy",  {31'd0, m_busy},  32'd0);
    chk("rst_done",  {31'd0, m_done},  32'd0);
    chk("rst_full",  {31'd0, m_full},  32'd0);
    chk("rst_err",   {31'd0, m_err},   32'd0);
    chk("rst_cnt",   {23'd0, m_cnt},   32'd0);
    chk("rst_addr",  {24'd0, m_addr},  32'd0);
    chk("rst_wdata", {8'd0, m_wdata},  32'd0);
    rst = 1'b0;
    tick();

    // single R bundle closing the session
    pulse_start();
    chk("run_busy",  {31'd0, m_busy},  32'd1);
    chk("run_ready", {31'd0, m_ready}, 32'd1);
    bundle(2'b00, 6'h2A, 4'd3, 4'd5, 4'd9, 16'h0000, 1'b1);
    tick(); no_bundle();
    chk("r_we",    {31'd0, m_we},    32'd1);
    chk("r_addr",  {24'd0, m_addr},  32'h00);
    chk("r_wdata", {8'd0, m_wdata},  32'h2A3590);
    chk("r_done",  {31'd0, m_done},  32'd1);
    chk("r_cnt",   {23'd0, m_cnt},   32'd1);
    chk("r_err",   {31'd0, m_err},   32'd0);
    chk("r_ready", {31'd0, m_ready}, 32'd0);
    tick();
    chk("r_we_off", {31'd0, m_we}, 32'd0);

    // I then U back-to-back
    pulse_start();
    bundle(2'b01, 6'd5, 4'd2, 4'd0, 4'd7, 16'h03FF, 1'b0);
    chk("iu_ready0", {31'd0, m_ready}, 32'd1);
    tick();
    chk("i_we",    {31'd0, m_we},   32'd1);
    chk("i_addr",  {24'd0, m_addr}, 32'h00);
    chk("i_wdata", {8'd0, m_wdata}, 32'h549FFF);
    bundle(2'b11, 6'd2, 4'd0, 4'd0, 4'hA, 16'hBEEF, 1'b1);
    chk("iu_ready1", {31'd0, m_ready}, 32'd1);
    tick(); no_bundle();
    chk("u_we",    {31'd0, m_we},   32'd1);
    chk("u_addr",  {24'd0, m_addr}, 32'h01);
    chk("u_wdata", {8'd0, m_wdata}, 32'hEABEEF);
    chk("u_cnt",   {23'd0, m_cnt},  32'd2);
    chk("u_done",  {31'd0, m_done}, 32'd1);

    // rejections: I op too wide, I imm too wide, valid S, U op too wide with last
    pulse_start();
    bundle(2'b01, 6'h12, 4'd1, 4'd0, 4'd1, 16'h0001, 1'b0);
    tick();
    chk("rej_op_we",  {31'd0, m_we},  32'd0);
    chk("rej_op_err", {31'd0, m_err}, 32'd1);
    chk("rej_op_cnt", {23'd0, m_cnt}, 32'd0);
    bundle(2'b01, 6'd1, 4'd1, 4'd0, 4'd1, 16'h0400, 1'b0);
    tick();
    chk("rej_imm_we",   {31'd0, m_we},   32'd0);
    chk("rej_imm_busy", {31'd0, m_busy}, 32'd1);
    bundle(2'b10, 6'd3, 4'd1, 4'd2, 4'd0, 16'h0004, 1'b0);
    tick();
    chk("s_we",    {31'd0, m_we},   32'd1);
    chk("s_addr",  {24'd0, m_addr}, 32'h00);
    chk("s_wdata", {8'd0, m_wdata}, 32'h8C4804);
    chk("s_cnt",   {23'd0, m_cnt},  32'd1);
    chk("s_err",   {31'd0, m_err},  32'd1);
    bundle(2'b11, 6'd4, 4'd0, 4'd0, 4'd1, 16'h1234, 1'b1);
    tick(); no_bundle();
    chk("rej_last_we",   {31'd0, m_we},   32'd0);
    chk("rej_last_done", {31'd0, m_done}, 32'd1);
    chk("rej_last_cnt",  {23'd0, m_cnt},  32'd1);

    // DEPTH=4 stop and address wrap; five bundles offered, last never set
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      bundle(2'b00, 6'(i + 1), 4'd1, 4'd2, 4'd3, 16'h0000, 1'b0);
      tick();
      chk("d4_we",    {31'd0, d_we},   32'd1);
      chk("d4_addr",  {24'd0, d_addr}, 32'(i));
      chk("wrap_we",  {31'd0, w_we},   32'd1);
      chk("wrap_addr", {24'd0, w_addr}, 32'((8'hFE + i) % 256));
      chk("wrap_wdata", {8'd0, w_wdata}, ((i + 1) << 16) | 32'h1230);
    end
    chk("d4_done",  {31'd0, d_done},  32'd1);
    chk("d4_full",  {31'd0, d_full},  32'd1);
    chk("d4_ready", {31'd0, d_ready}, 32'd0);
    chk("wrap_full", {31'd0, w_full}, 32'd1);
    chk("main_not_full", {31'd0, m_full}, 32'd0);
    bundle(2'b00, 6'd5, 4'd1, 4'd2, 4'd3, 16'h0000, 1'b0);
    tick(); no_bundle();
    chk("d4_fifth_we",  {31'd0, d_we},  32'd0);
    chk("d4_fifth_cnt", {23'd0, d_cnt}, 32'd4);
    chk("wrap_fifth_we", {31'd0, w_we}, 32'd0);

    // reset mid-session, start ignored in RUN
    rst = 1'b1; tick(); rst = 1'b0;
    pulse_start();
    bundle(2'b00, 6'h11, 4'd1, 4'd2, 4'd3, 16'h0000, 1'b0);
    tick();
    chk("m6_addr0", {24'd0, m_addr}, 32'h00);
    tick(); no_bundle();
    chk("m6_addr1", {24'd0, m_addr}, 32'h01);
    pulse_start();
    chk("m6_start_busy", {31'd0, m_busy}, 32'd1);
    bundle(2'b00, 6'h11, 4'd1, 4'd2, 4'd3, 16'h0000, 1'b0);
    tick();
    chk("m6_ign_addr", {24'd0, m_addr}, 32'h02);
    chk("m6_ign_cnt",  {23'd0, m_cnt},  32'd3);
    bundle(2'b01, 6'h20, 4'd1, 4'd2, 4'd3, 16'h0000, 1'b0);
    tick(); no_bundle();
    chk("m6_err_set", {31'd0, m_err}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("m6_rst_we",    {31'd0, m_we},    32'd0);
    chk("m6_rst_err",   {31'd0, m_err},   32'd0);
    chk("m6_rst_cnt",   {23'd0, m_cnt},   32'd0);
    chk("m6_rst_busy",  {31'd0, m_busy},  32'd0);
    chk("m6_rst_ready", {31'd0, m_ready}, 32'd0);
    chk("m6_rst_addr",  {24'd0, m_addr},  32'd0);
    chk("m6_rst_wdata", {8'd0, m_wdata},  32'd0);
    pulse_start();
    bundle(2'b00, 6'h11, 4'd1, 4'd2, 4'd3, 16'h0000, 1'b1);
    tick(); no_bundle();
    chk("m6_new_we",    {31'd0, m_we},   32'd1);
    chk("m6_new_addr",  {24'd0, m_addr}, 32'h00);
    chk("m6_new_wdata", {8'd0, m_wdata}, 32'h111230);
    chk("m6_new_cnt",   {23'd0, m_cnt},  32'd1);
    chk("m6_new_err",   {31'd0, m_err},  32'd0);
    chk("m6_new_done",  {31'd0, m_done}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
